cam_fb_writer: RTL and testbench
================================

# cam_fb_writer

Camera capture writer for the QVGA frame buffer. Receives the OV7670-style 8-bit byte stream (VSYNC/HREF framed), assembles RGB565 pixels and issues single-cycle writes at the linear address `y*320 + x`. This is the write side of the buffer that the VGA memory controller reads and upscales. It runs entirely in the camera pixel-clock domain; the frame buffer's write port is clocked by the same clock.

## Interface
Parameters:
- `H_RES`, 320: pixels per stored line.
- `V_RES`, 240: stored lines per frame.
- `ADDR_W`, 17: write address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES.

Ports:
- `clk`, in, 1: camera PCLK, the only clock.
- `reset`, in, 1: synchronous, active-high.
- `vsync`, in, 1: camera VSYNC; high during inter-frame blanking.
- `href`, in, 1: camera HREF; high while line bytes are valid.
- `data`, in, 8: camera byte; one byte per `clk` while `href` = 1.
- `cap_en`, in, 1: capture enable; sampled only at frame start.
- `we`, out, 1: frame buffer write strobe, one cycle per pixel.
- `wAddr`, out, ADDR_W: write address.
- `wData`, out, 16: RGB565 pixel, {R[4:0], G[5:0], B[4:0]}.
- `frame_done`, out, 1: one-cycle pulse at the end of a captured frame.
- `busy`, out, 1: high while in ACTIVE.

## Operation
- Input registers: `vsync`, `href` and `data` are registered once. All edge detection uses the registered value and its one-cycle-delayed copy.
- FSM states:
  - IDLE: entered from reset. Goes to SYNC when `vsync` = 1.
  - SYNC: waits for the falling edge of `vsync`. At that edge, goes to ACTIVE if `cap_en` = 1, otherwise to IDLE, which skips the frame.
  - ACTIVE: captures pixels. On the rising edge of `vsync`, pulses `frame_done` and goes to SYNC.
- Because of the IDLE state, a reset in the middle of a frame never writes a partial frame. Capture resumes at the next full frame.
- Byte pairing:
  - A phase bit clears at each `href` rising edge.
  - The first byte of a pair is the high byte: data[7:3] = R, data[2:0] = G[5:3].
  - The second byte is the low byte: data[7:5] = G[2:0], data[4:0] = B.
  - The pixel completes on the second byte.
- Counters:
  - `x_cnt` (10 bits) increments per completed pixel and clears at each `href` falling edge.
  - `y_cnt` (9 bits) increments at each `href` falling edge while in ACTIVE. It clears on entry to ACTIVE.
- A write occurs only if `x_cnt < H_RES` and `y_cnt < V_RES`. Surplus pixels and lines are dropped silently, with no wrap-around.
- If `href` falls on an odd byte count, the half-pixel is discarded and no write is issued.
- Address: `wAddr` = `y_cnt*H_RES + x_cnt`, computed at full width and then truncated to ADDR_W. Range is 0 to 76799.
- `href` pulses outside ACTIVE are ignored.

## Timing
- Reset values: `we` = 0, `wAddr` = 0, `wData` = 0, `frame_done` = 0, `busy` = 0; state = IDLE; counters and phase = 0.
- Latency: a byte on `data` at edge N is registered at N. If it is a second byte, `we`, `wAddr` and `wData` are valid after edge N+1, for one cycle. Latency is 2 clocks from pin to write.
- `wAddr` and `wData` hold their last value when `we` = 0.
- `frame_done` is asserted for exactly one cycle, 2 clocks after the `vsync` rising edge at the pins.
- `vsync` rising while `href` = 1: the frame ends immediately and the in-flight half-pixel is dropped.
- Maximum write rate: one write every 2 clocks.

## Configuration
- `CAM_DOWNSCALE_EN`, defined: the camera delivers 640x480.
  - Only pixels with an even raw pixel index and lines with an even raw line index are written.
  - Raw counters are 10 bits; the stored coordinates are raw >> 1.
  - The write rate drops to one write every 4 clocks.
- `CAM_DOWNSCALE_EN`, undefined: the camera delivers 320x240 and every pixel is written. This is the behaviour described above.

## Structure
- Shared package `frame_pkg`:
  - QVGA constants: H_RES = 320, V_RES = 240, FB_DEPTH = 76800, ADDR_W = 17.
  - Typedef `rgb565_t`.
  - Capture state enum `cap_state_e` {IDLE, SYNC, ACTIVE}.
  - The VGA memory controller uses the same constants.
- One sub-module, `cam_pixel_assembler`: phase bit plus high-byte register. It outputs `pix_valid` and a 16-bit pixel, and is cleared on `href` rising.

## Test plan
- Reset, then one 320x240 frame with `cap_en` = 1 and pixel value = address[15:0] → 76800 writes, last `wAddr` = 76799, one `frame_done` pulse.
- Byte pair 0xF8, 0x1F → `wData` = 0xF81F; pair 0x07, 0xE0 → `wData` = 0x07E0.
- Line of 330 pixels and 245 lines → writes only for x < 320 and y < 240; no address above 76799.
- Line with 641 bytes → 320 writes and the odd byte discarded; the next line's first write is at `wAddr` = 320*(y+1).
- `cap_en` = 0 at the `vsync` falling edge → zero writes that frame. Raising `cap_en` mid-frame changes nothing; the next frame is captured.
- `reset` asserted mid-frame at line 100 → no writes until after the next full `vsync` high-then-low sequence. The first write after that is at `wAddr` = 0.

Source files
------------

// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the QVGA frame buffer: geometry constants used by
// both the camera write side (cam_fb_writer) and the VGA read side, the
// RGB565 pixel type, the capture FSM state encoding and the byte-pair to
// RGB565 packing helper.
// ---------------------------------------------------------------------------
package frame_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 17;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } cap_state_e;

  // The camera sends R[4:0],G[5:3] first and G[2:0],B[4:0] second.
  function automatic rgb565_t rgb565_from_bytes(input logic [7:0] hi_byte,
                                                input logic [7:0] lo_byte);
    rgb565_t pix;
    pix.r = hi_byte[7:3];
    pix.g = {hi_byte[2:0], lo_byte[7:5]};
    pix.b = lo_byte[4:0];
    return pix;
  endfunction

endpackage

// File: rtl/cam_pixel_assembler.sv
// ---------------------------------------------------------------------------
// cam_pixel_assembler
// Pairs consecutive camera bytes into RGB565 pixels. A phase bit tracks
// whether the current byte is the first (high) or second (low) byte of a
// pair; it is forced back to "first" at every href rising edge so a line
// always starts pair-aligned. pix_valid is combinational on the current
// (already registered) byte so the parent can register the write one clock
// later.
// Ports:
//   clk, reset     camera clock, synchronous active-high reset
//   href           registered HREF
//   href_rise      rising edge of the registered HREF
//   data           registered camera byte
//   pix_valid      current byte completes a pixel
//   pixel          assembled RGB565 pixel (valid with pix_valid)
// ---------------------------------------------------------------------------
module cam_pixel_assembler
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       href,
  input  logic       href_rise,
  input  logic [7:0] data,
  output logic       pix_valid,
  output rgb565_t    pixel
);

  logic       phase_r;
  logic [7:0] hi_byte_r;

  // Phase toggle and high-byte capture; the first byte of a line seeds the pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r   <= 1'b0;
      hi_byte_r <= 8'd0;
    end else if (href_rise) begin
      phase_r   <= 1'b1;
      hi_byte_r <= data;
    end else if (href) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        hi_byte_r <= data;
      end
    end else begin
      phase_r <= 1'b0;
    end
  end

  // A byte arriving on the href rising edge is always a first byte.
  assign pix_valid = href & phase_r & ~href_rise;
  assign pixel     = rgb565_from_bytes(hi_byte_r, data);

endmodule

// File: rtl/cam_fb_writer.sv
// ---------------------------------------------------------------------------
// cam_fb_writer
// Camera capture writer for the QVGA frame buffer. Registers the camera
// VSYNC/HREF/byte stream once, assembles RGB565 pixels and issues one-cycle
// writes at y*H_RES + x. Frames are only captured from a clean VSYNC
// falling edge with cap_en high, so a reset mid-frame never produces a
// partial frame.
//
// Optional build macro CAM_DOWNSCALE_EN: the camera delivers 640x480 and
// only even raw pixels on even raw lines are stored at (raw >> 1).
//
// Ports:
//   clk         camera PCLK (also the frame buffer write clock)
//   reset       synchronous, active-high
//   vsync       camera VSYNC, high during inter-frame blanking
//   href        camera HREF, high while line bytes are valid
//   data        camera byte
//   cap_en      capture enable, sampled at frame start
//   we          write strobe, one cycle per stored pixel
//   wAddr       write address (holds when we = 0)
//   wData       RGB565 pixel {R,G,B} (holds when we = 0)
//   frame_done  one-cycle pulse at the end of a captured frame
//   busy        high while a frame is being captured
// ---------------------------------------------------------------------------
module cam_fb_writer #(
  parameter int H_RES  = frame_pkg::H_RES,
  parameter int V_RES  = frame_pkg::V_RES,
  parameter int ADDR_W = frame_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  input  logic              cap_en,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              busy
);

  localparam int X_CNT_W = 10;
`ifdef CAM_DOWNSCALE_EN
  localparam int Y_CNT_W = 10;
`else
  localparam int Y_CNT_W = 9;
`endif
  localparam logic [X_CNT_W-1:0] X_MAX = {X_CNT_W{1'b1}};
  localparam logic [Y_CNT_W-1:0] Y_MAX = {Y_CNT_W{1'b1}};
  localparam logic [X_CNT_W-1:0] X_ONE = {{(X_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [Y_CNT_W-1:0] Y_ONE = {{(Y_CNT_W-1){1'b0}}, 1'b1};

  logic                 vsync_r;
  logic                 vsync_d_r;
  logic                 href_r;
  logic                 href_d_r;
  logic [7:0]           data_r;

  logic                 vsync_rise_s;
  logic                 vsync_fall_s;
  logic                 href_rise_s;
  logic                 href_fall_s;

  logic                 pix_valid_s;
  frame_pkg::rgb565_t   pixel_s;

  frame_pkg::cap_state_e state_r;
  logic [X_CNT_W-1:0]   x_cnt_r;
  logic [Y_CNT_W-1:0]   y_cnt_r;

  logic [X_CNT_W-1:0]   x_pos_s;
  logic [Y_CNT_W-1:0]   y_pos_s;
  logic                 keep_s;
  logic                 in_range_s;
  logic                 wr_s;
  logic [ADDR_W-1:0]    addr_s;

  // Single register stage on the camera pins plus delayed copies for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_r   <= 1'b0;
      vsync_d_r <= 1'b0;
      href_r    <= 1'b0;
      href_d_r  <= 1'b0;
      data_r    <= 8'd0;
    end else begin
      vsync_r   <= vsync;
      vsync_d_r <= vsync_r;
      href_r    <= href;
      href_d_r  <= href_r;
      data_r    <= data;
    end
  end

  assign vsync_rise_s =  vsync_r & ~vsync_d_r;
  assign vsync_fall_s = ~vsync_r &  vsync_d_r;
  assign href_rise_s  =  href_r  & ~href_d_r;
  assign href_fall_s  = ~href_r  &  href_d_r;

  cam_pixel_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .href      (href_r),
    .href_rise (href_rise_s),
    .data      (data_r),
    .pix_valid (pix_valid_s),
    .pixel     (pixel_s)
  );

`ifdef CAM_DOWNSCALE_EN
  // Raw 640x480 coordinates: keep even pixels on even lines, store at half.
  assign x_pos_s = x_cnt_r >> 1;
  assign y_pos_s = y_cnt_r >> 1;
  assign keep_s  = ~x_cnt_r[0] & ~y_cnt_r[0];
`else
  assign x_pos_s = x_cnt_r;
  assign y_pos_s = y_cnt_r;
  assign keep_s  = 1'b1;
`endif

  // Surplus pixels/lines are dropped rather than wrapped into the buffer.
  assign in_range_s = (32'(x_pos_s) < 32'(H_RES)) && (32'(y_pos_s) < 32'(V_RES));
  assign addr_s     = ADDR_W'(32'(y_pos_s) * 32'(H_RES) + 32'(x_pos_s));

  // A VSYNC rise ends the frame at once, so a pixel completing alongside it is dropped.
  assign wr_s = (state_r == frame_pkg::ACTIVE) & pix_valid_s & keep_s & in_range_s
              & ~vsync_rise_s;

  // Capture FSM, pixel/line counters and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= frame_pkg::IDLE;
      x_cnt_r    <= {X_CNT_W{1'b0}};
      y_cnt_r    <= {Y_CNT_W{1'b0}};
      we         <= 1'b0;
      wAddr      <= {ADDR_W{1'b0}};
      wData      <= 16'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;

      if (href_fall_s) begin
        x_cnt_r <= {X_CNT_W{1'b0}};
      end else if (pix_valid_s && (x_cnt_r != X_MAX)) begin
        x_cnt_r <= x_cnt_r + X_ONE;
      end

      if (wr_s) begin
        we    <= 1'b1;
        wAddr <= addr_s;
        wData <= pixel_s;
      end

      case (state_r)
        frame_pkg::IDLE: begin
          busy <= 1'b0;
          if (vsync_r) begin
            state_r <= frame_pkg::SYNC;
          end
        end
        frame_pkg::SYNC: begin
          busy <= 1'b0;
          if (vsync_fall_s) begin
            if (cap_en) begin
              state_r <= frame_pkg::ACTIVE;
              busy    <= 1'b1;
              x_cnt_r <= {X_CNT_W{1'b0}};
              y_cnt_r <= {Y_CNT_W{1'b0}};
            end else begin
              state_r <= frame_pkg::IDLE;
            end
          end
        end
        frame_pkg::ACTIVE: begin
          busy <= 1'b1;
          if (vsync_rise_s) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state_r    <= frame_pkg::SYNC;
          end else if (href_fall_s && (y_cnt_r != Y_MAX)) begin
            y_cnt_r <= y_cnt_r + Y_ONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= frame_pkg::IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_cam_fb_writer
// Directed bench for cam_fb_writer (default 320x240 build). Inputs change
// 1 time unit after each rising edge; outputs are sampled at the same point
// and folded into write statistics (count, first/last/max address, data vs
// address agreement, back-to-back strobes, frame_done pulses).
// ---------------------------------------------------------------------------
module tb_cam_fb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        cap_en;
  logic        we;
  logic [16:0] wAddr;
  logic [15:0] wData;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          wr_cnt;
  int          fd_cnt;
  int          b2b_cnt;
  int          data_err;
  int          probe_idx;
  logic [16:0] first_addr;
  logic [16:0] last_addr;
  logic [16:0] max_addr;
  logic [16:0] probe_addr;
  logic        prev_we;
  bit          data_mode;

  always #5 clk = ~clk;

  cam_fb_writer dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .href       (href),
    .data       (data),
    .cap_en     (cap_en),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt     = 0;
    fd_cnt     = 0;
    b2b_cnt    = 0;
    data_err   = 0;
    probe_idx  = -1;
    first_addr = 17'd0;
    last_addr  = 17'd0;
    max_addr   = 17'd0;
    probe_addr = 17'd0;
  endtask

  // One clock: wait for the edge, then sample the write port.
  task automatic tick();
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      wr_cnt++;
      if (wr_cnt == 1) first_addr = wAddr;
      if (wr_cnt == probe_idx) probe_addr = wAddr;
      last_addr = wAddr;
      if (wAddr > max_addr) max_addr = wAddr;
      if (data_mode && (wData !== wAddr[15:0])) data_err++;
      if (prev_we === 1'b1) b2b_cnt++;
    end
    prev_we = we;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    data = b;
    tick();
  endtask

  task automatic idle(input int n);
    href = 1'b0;
    data = 8'd0;
    repeat (n) tick();
  endtask

  // Pixel (x,y) carries the value y*320+x so each write can be checked against its address.
  task automatic send_line(input int y, input int npix, input bit odd_byte);
    logic [15:0] v;
    for (int x = 0; x < npix; x++) begin
      v = 16'(y * 320 + x);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
    end
    if (odd_byte) send_byte(8'hA5);
    idle(3);
  endtask

  // A single-byte HREF pulse: counts as a line but never completes a pixel.
  task automatic stub_line();
    send_byte(8'h55);
    idle(3);
  endtask

  task automatic frame_start();
    vsync = 1'b0;
    idle(4);
  endtask

  // Raise VSYNC and check the frame_done pulse lands exactly 2 clocks later.
  task automatic frame_end(input bit exp_fd);
    vsync = 1'b1;
    tick();
    check_eq("fd_early", 32'(frame_done), 32'd0);
    tick();
    check_eq("fd_pulse", 32'(frame_done), 32'(exp_fd));
    tick();
    check_eq("fd_single", 32'(frame_done), 32'd0);
    idle(2);
  endtask

  initial begin
    reset     = 1'b1;
    vsync     = 1'b0;
    href      = 1'b0;
    data      = 8'd0;
    cap_en    = 1'b0;
    prev_we   = 1'b0;
    data_mode = 1'b0;
    clear_mon();
    repeat (3) tick();
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_waddr", 32'(wAddr), 32'd0);
    check_eq("rst_wdata", 32'(wData), 32'd0);
    check_eq("rst_fd", 32'(frame_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Frame A: boundary frame; lines 0,1 full, 2..238 stubs, 239..244 at 330 pixels.
    cap_en    = 1'b1;
    data_mode = 1'b1;
    vsync     = 1'b1;
    idle(4);
    clear_mon();
    frame_start();
    check_eq("a_busy", 32'(busy), 32'd1);
    send_line(0, 320, 1'b0);
    send_line(1, 320, 1'b0);
    for (int y = 2; y < 239; y++) stub_line();
    for (int y = 239; y < 245; y++) send_line(y, 330, 1'b0);
    frame_end(1'b1);
    check_eq("a_writes", 32'(wr_cnt), 32'd960);
    check_eq("a_first", 32'(first_addr), 32'd0);
    check_eq("a_last", 32'(last_addr), 32'd76799);
    check_eq("a_max", 32'(max_addr), 32'd76799);
    check_eq("a_data", 32'(data_err), 32'd0);
    check_eq("a_fdcnt", 32'(fd_cnt), 32'd1);
    check_eq("a_rate", 32'(b2b_cnt), 32'd0);
    check_eq("a_busy_end", 32'(busy), 32'd0);

    // Frame B: colour pairs and pin-to-write latency.
    data_mode = 1'b0;
    clear_mon();
    frame_start();
    send_byte(8'hF8);
    send_byte(8'h1F);
    check_eq("b_lat_early", 32'(we), 32'd0);
    send_byte(8'h07);
    check_eq("b_we0", 32'(we), 32'd1);
    check_eq("b_data0", 32'(wData), 32'h0000F81F);
    check_eq("b_addr0", 32'(wAddr), 32'd0);
    send_byte(8'hE0);
    check_eq("b_gap", 32'(we), 32'd0);
    idle(1);
    check_eq("b_we1", 32'(we), 32'd1);
    check_eq("b_data1", 32'(wData), 32'h000007E0);
    check_eq("b_addr1", 32'(wAddr), 32'd1);
    idle(3);
    check_eq("b_hold_data", 32'(wData), 32'h000007E0);
    check_eq("b_hold_addr", 32'(wAddr), 32'd1);
    frame_end(1'b1);
    check_eq("b_writes", 32'(wr_cnt), 32'd2);

    // Frame C: 641-byte line, odd byte dropped; next line starts at 320.
    data_mode = 1'b1;
    clear_mon();
    probe_idx = 321;
    frame_start();
    send_line(0, 320, 1'b1);
    send_line(1, 2, 1'b0);
    frame_end(1'b1);
    check_eq("c_writes", 32'(wr_cnt), 32'd322);
    check_eq("c_line1_first", 32'(probe_addr), 32'd320);
    check_eq("c_last", 32'(last_addr), 32'd321);
    check_eq("c_data", 32'(data_err), 32'd0);

    // Frame D: cap_en low at frame start skips the frame even if raised later.
    cap_en = 1'b0;
    clear_mon();
    frame_start();
    check_eq("d_busy", 32'(busy), 32'd0);
    send_line(0, 4, 1'b0);
    cap_en = 1'b1;
    send_line(1, 4, 1'b0);
    frame_end(1'b0);
    check_eq("d_skip_writes", 32'(wr_cnt), 32'd0);
    clear_mon();
    frame_start();
    send_line(0, 4, 1'b0);
    frame_end(1'b1);
    check_eq("d_next_writes", 32'(wr_cnt), 32'd4);
    check_eq("d_next_last", 32'(last_addr), 32'd3);
    check_eq("d_next_data", 32'(data_err), 32'd0);

    // Frame E: reset in the middle of line 100; nothing written until a full VSYNC cycle.
    clear_mon();
    frame_start();
    for (int y = 0; y < 100; y++) stub_line();
    for (int x = 0; x < 10; x++) begin
      send_byte(8'h12);
      send_byte(8'h34);
    end
    reset = 1'b1;
    send_byte(8'h56);
    send_byte(8'h78);
    check_eq("e_rst_we", 32'(we), 32'd0);
    check_eq("e_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    clear_mon();
    for (int x = 0; x < 10; x++) begin
      send_byte(8'h9A);
      send_byte(8'hBC);
    end
    idle(3);
    send_line(101, 5, 1'b0);
    check_eq("e_no_writes", 32'(wr_cnt), 32'd0);
    check_eq("e_idle_busy", 32'(busy), 32'd0);
    frame_end(1'b0);
    frame_start();
    send_line(0, 3, 1'b0);
    check_eq("e_writes", 32'(wr_cnt), 32'd3);
    check_eq("e_first", 32'(first_addr), 32'd0);
    check_eq("e_data", 32'(data_err), 32'd0);
    frame_end(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
